// File: rtl/arb_pkg.sv
// Shared FSM encoding for the round-robin arbiter family.
package arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

endpackage

// File: rtl/decoder_param_en.sv
// Binary-to-one-hot decoder with enable; output is all-zero when en=0.
module decoder_param_en #(
  parameter int BITS = 2,
  parameter int SIZE = 4
) (
  input  logic [BITS-1:0] in,
  input  logic            en,
  output logic [SIZE-1:0] out
);

  always_comb begin
    out = '0;
    for (int i = 0; i < SIZE; i++) begin
      out[i] = en && (in == BITS'(i));
    end
  end

endmodule

// File: rtl/rr_arb_idx.sv
// Round-robin arbiter with registered binary grant index and one-hot decode.
// Optional hold-timeout forced release under macro RR_ARB_TIMEOUT_EN.
module rr_arb_idx
  import arb_pkg::*;
#(
  parameter int BITS    = 2,
  parameter int SIZE    = 4,
  parameter int TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [SIZE-1:0] req,
  input  logic            done,
  output logic [BITS-1:0] grant_idx,
  output logic            grant_vld,
  output logic [SIZE-1:0] grant_oh,
  output logic            timeout
);

  // An illegal parameter set keeps the arbiter permanently idle.
  localparam bit CFG_OK = (SIZE >= 2) && (SIZE <= (1 << BITS)) && (TIMEOUT >= 1);

  state_t            state;
  logic [BITS-1:0]   ptr;
  logic [BITS-1:0]   pick;
  logic [BITS-1:0]   nxt;
  logic [BITS-1:0]   off;
  logic [BITS:0]     sum;
  logic [2*SIZE-1:0] dbl;
  logic [SIZE-1:0]   rot;
  logic              any;
  logic              own_req;
  logic              rel_norm;
  logic              rel_force;

  // Rotate requests so bit 0 is the requester at ptr, then take the lowest set bit.
  always_comb begin
    dbl = {req, req} >> ptr;
    rot = dbl[SIZE-1:0];
    off = '0;
    for (int i = SIZE - 1; i >= 0; i--) begin
      if (rot[i]) off = BITS'(i);
    end
    sum = {1'b0, ptr} + {1'b0, off};
    if (sum >= (BITS+1)'(SIZE)) sum = sum - (BITS+1)'(SIZE);
    pick = sum[BITS-1:0];
    any  = CFG_OK && (|req);
  end

  always_comb begin
    nxt = (grant_idx == BITS'(SIZE - 1)) ? '0 : grant_idx + 1'b1;
  end

  assign own_req  = |(req & grant_oh);
  assign rel_norm = done | ~own_req;

`ifdef RR_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt;
  logic             to_r;

  assign rel_force = (cnt == CNT_W'(TIMEOUT - 1)) & ~rel_norm;
  assign timeout   = to_r;
`else
  assign rel_force = 1'b0;
  assign timeout   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      grant_idx <= '0;
      grant_vld <= 1'b0;
`ifdef RR_ARB_TIMEOUT_EN
      cnt       <= '0;
      to_r      <= 1'b0;
`endif
    end else begin
`ifdef RR_ARB_TIMEOUT_EN
      to_r <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (any) begin
            state     <= GRANT;
            grant_idx <= pick;
            grant_vld <= 1'b1;
`ifdef RR_ARB_TIMEOUT_EN
            cnt       <= '0;
`endif
          end
        end
        GRANT: begin
`ifdef RR_ARB_TIMEOUT_EN
          cnt <= cnt + 1'b1;
`endif
          if (rel_norm | rel_force) begin
            state     <= IDLE;
            grant_vld <= 1'b0;
            ptr       <= nxt;
`ifdef RR_ARB_TIMEOUT_EN
            to_r      <= rel_force;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  decoder_param_en #(
    .BITS (BITS),
    .SIZE (SIZE)
  ) u_dec (
    .in  (grant_idx),
    .en  (grant_vld),
    .out (grant_oh)
  );

endmodule

// File: tb/tb_rr_arb_idx.sv
// Randomized and directed bench for rr_arb_idx against a cycle-level reference model.
module tb_rr_arb_idx;

  localparam int BITS    = 2;
  localparam int SIZE    = 4;
  localparam int TIMEOUT = 15;
`ifdef RR_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic [SIZE-1:0] req;
  logic            done;
  logic [BITS-1:0] grant_idx;
  logic            grant_vld;
  logic [SIZE-1:0] grant_oh;
  logic            timeout;

  int total = 0;
  int bad   = 0;

  // Reference model state: owner index, pointer, cycles held, timeout pulse.
  int m_vld, m_idx, m_ptr, m_hold, m_to;

  rr_arb_idx #(
    .BITS    (BITS),
    .SIZE    (SIZE),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .done      (done),
    .grant_idx (grant_idx),
    .grant_vld (grant_vld),
    .grant_oh  (grant_oh),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got=%0h expected=%0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_step();
    if (rst) begin
      m_vld = 0; m_idx = 0; m_ptr = 0; m_hold = 0; m_to = 0;
    end else if (m_vld == 0) begin
      m_to = 0;
      for (int k = 0; k < SIZE; k++) begin
        int j;
        j = (m_ptr + k) % SIZE;
        if (req[j]) begin
          m_vld = 1; m_idx = j; m_hold = 0;
          break;
        end
      end
    end else begin
      bit normal;
      bit forced;
      m_hold++;
      normal = done || !req[m_idx];
      forced = TO_EN && (m_hold >= TIMEOUT) && !normal;
      m_to   = forced ? 1 : 0;
      if (normal || forced) begin
        m_vld = 0;
        m_ptr = (m_idx + 1) % SIZE;
      end
    end
  endtask

  task automatic step(input logic [SIZE-1:0] r, input logic d, input logic rs);
    logic [SIZE-1:0] oh_exp;
    req = r; done = d; rst = rs;
    @(posedge clk);
    model_step();
    #1;
    oh_exp = (m_vld != 0) ? SIZE'(1 << m_idx) : '0;
    check_eq("grant_vld", grant_vld, m_vld);
    check_eq("grant_idx", grant_idx, m_idx);
    check_eq("grant_oh", grant_oh, oh_exp);
    check_eq("timeout", timeout, m_to);
  endtask

  int          order[$];
  int          pulses;
  logic        prev_vld;
  logic [SIZE-1:0] rq;
  int          exp_order[5] = '{0, 1, 2, 3, 0};

  initial begin
    req = '0; done = 1'b0; rst = 1'b1;

    // Reset held two cycles with every requester active.
    step(4'b1111, 1'b0, 1'b1);
    step(4'b1111, 1'b0, 1'b1);
    check_eq("rst_oh", grant_oh, 0);

    // Rotation with done pulsed in every grant cycle.
    prev_vld = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step(4'b1111, (k % 2) == 1, 1'b0);
      if (grant_vld && !prev_vld) order.push_back(int'(grant_idx));
      prev_vld = grant_vld;
    end
    check_eq("rot_cnt", order.size(), 5);
    for (int k = 0; k < 5 && k < order.size(); k++) check_eq("rot_seq", order[k], exp_order[k]);

    // Skip and wrap: bring ptr to 3, then only requester 1 asks.
    step(4'b0000, 1'b0, 1'b1);
    step(4'b0100, 1'b0, 1'b0);
    step(4'b0100, 1'b1, 1'b0);
    step(4'b0010, 1'b0, 1'b0);
    check_eq("skip_idx", grant_idx, 1);
    check_eq("skip_oh", grant_oh, 4'b0010);
    step(4'b0010, 1'b1, 1'b0);
    step(4'b1111, 1'b0, 1'b0);
    check_eq("skip_ptr", grant_idx, 2);

    // Owner 2 drops its request without done.
    step(4'b0100, 1'b1, 1'b0);
    step(4'b0100, 1'b0, 1'b0);
    step(4'b0100, 1'b0, 1'b0);
    step(4'b0000, 1'b0, 1'b0);
    check_eq("drop_vld", grant_vld, 0);
    step(4'b1111, 1'b0, 1'b0);
    check_eq("drop_ptr", grant_idx, 3);

    // Long hold by requester 0.
    step(4'b0000, 1'b0, 1'b1);
    step(4'b0001, 1'b0, 1'b0);
    pulses = 0;
    for (int k = 0; k < 20; k++) begin
      step(4'b0001, 1'b0, 1'b0);
      if (timeout) pulses++;
    end
    check_eq("to_pulses", pulses, TO_EN ? 1 : 0);

    // Reset in the middle of a grant to owner 1.
    step(4'b0000, 1'b0, 1'b1);
    step(4'b0010, 1'b0, 1'b0);
    step(4'b0010, 1'b0, 1'b1);
    check_eq("rmid_vld", grant_vld, 0);
    step(4'b0110, 1'b0, 1'b0);
    check_eq("rmid_idx", grant_idx, 1);

    // Random traffic with persistent requests, occasional done and reset.
    rq = 4'b1010;
    for (int k = 0; k < 3000; k++) begin
      for (int b = 0; b < SIZE; b++) begin
        if ($urandom_range(0, 9) == 0) rq[b] = ~rq[b];
      end
      step(rq, $urandom_range(0, 11) == 0, $urandom_range(0, 199) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
